// File: rtl/mipi_frame_decoder.sv
// Parses SOF / METADATA / PAYLOAD / EOF framing from the MIPI RX word stream and
// commits a frame's payload bytes to the downstream byte FIFO only after a valid EOF.
module mipi_frame_decoder #(
  parameter int MAX_PAYLOAD = 16,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic        rx_pixel_clk,
  input  logic        rst,
  input  logic [63:0] mipi_data,
  input  logic        mipi_valid,
  input  logic        fifo_full,
  output logic [7:0]  fifo_data,
  output logic        fifo_we,
  output logic [7:0]  channel,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [2:0]  state
);

  localparam int IW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [47:0] SOF_FW = 48'hEAFF99DEADFF;
  localparam logic [47:0] EOF_FW = 48'hEAFF99DEADAA;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_META     = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_WAIT_EOF = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rem_q, rem_d, wr_q, wr_d, rd_q, rd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    chan_pend_q, chan_pend_d, channel_q, channel_d;
  logic          done_q, done_d, err_q, err_d;
  logic [2:0]    code_q, code_d;

  logic [7:0]    buf_mem [2**AW];
  logic          buf_we;
  logic          err_hit;
  logic [2:0]    err_val;

  logic [47:0]   fw;
  logic [23:0]   len;
  logic          pad_bad, is_sof, is_eof;

  // Bytes arrive little-end first on the wire; fw puts the first byte on top.
  assign fw      = {mipi_data[7:0], mipi_data[15:8], mipi_data[23:16],
                    mipi_data[31:24], mipi_data[39:32], mipi_data[47:40]};
  assign len     = fw[39:16];
  assign pad_bad = |mipi_data[63:48];
  assign is_sof  = !pad_bad && (fw == SOF_FW);
  assign is_eof  = !pad_bad && (fw == EOF_FW);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    gap_d       = '0;
    chan_pend_d = chan_pend_q;
    channel_d   = channel_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    buf_we      = 1'b0;
    fifo_we     = 1'b0;
    err_hit     = 1'b0;
    err_val     = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (mipi_valid && is_sof) begin
          state_d = S_META;
          wr_d    = '0;
        end
      end
      S_META, S_PAYLOAD, S_WAIT_EOF: begin
        if (!mipi_valid) begin
          gap_d = gap_q + 1'b1;
          if (gap_d == GW'(GAP_TIMEOUT)) begin
            err_hit = 1'b1;
            err_val = 3'd5;
          end
        end else if (is_sof) begin
          // Resync: the new SOF starts a fresh frame rather than returning to IDLE.
          err_hit = 1'b1;
          err_val = 3'd7;
        end else if (pad_bad) begin
          err_hit = 1'b1;
          err_val = 3'd3;
        end else begin
          case (state_q)
            S_META: begin
              if (fw[47:40] != 8'h02) begin
                err_hit = 1'b1;
                err_val = 3'd1;
              end else if (len == 24'd0 || len > 24'(MAX_PAYLOAD)) begin
                err_hit = 1'b1;
                err_val = 3'd2;
              end else begin
                chan_pend_d = fw[15:8];
                rem_d       = IW'(len);
                state_d     = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              if (fw[47:8] != 40'd0) begin
                err_hit = 1'b1;
                err_val = 3'd3;
              end else begin
                buf_we = 1'b1;
                wr_d   = wr_q + 1'b1;
                rem_d  = rem_q - 1'b1;
                if (rem_q == IW'(1)) state_d = S_WAIT_EOF;
              end
            end
            S_WAIT_EOF: begin
              if (is_eof) begin
                state_d   = S_DRAIN;
                done_d    = 1'b1;
                channel_d = chan_pend_q;
                rd_d      = '0;
              end else begin
                err_hit = 1'b1;
                err_val = 3'd4;
              end
            end
            default: ;
          endcase
        end
      end
      S_DRAIN: begin
        // An SOF here is reported and dropped; the committed frame keeps draining.
        if (mipi_valid && is_sof) begin
          err_d  = 1'b1;
          code_d = 3'd6;
        end
        if (!fifo_full) begin
          fifo_we = 1'b1;
          rd_d    = rd_q + 1'b1;
          if (rd_q + 1'b1 == wr_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_hit) begin
      err_d   = 1'b1;
      code_d  = err_val;
      wr_d    = '0;
      gap_d   = '0;
      state_d = (err_val == 3'd7) ? S_META : S_IDLE;
    end
  end

  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      gap_q       <= '0;
      chan_pend_q <= '0;
      channel_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      gap_q       <= gap_d;
      chan_pend_q <= chan_pend_d;
      channel_q   <= channel_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  // Staging buffer holds data only; validity is tracked by wr_q/rd_q.
  always_ff @(posedge rx_pixel_clk) begin
    if (buf_we) buf_mem[wr_q[AW-1:0]] <= fw[7:0];
  end

  assign fifo_data  = fifo_we ? buf_mem[rd_q[AW-1:0]] : 8'h00;
  assign channel    = channel_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mipi_frame_decoder.sv
// Scoreboard bench for mipi_frame_decoder: frame-level reference model predicts
// committed bytes, done channels and error codes; a monitor pops and compares.
module tb_mipi_frame_decoder;

  localparam int MAXP = 16;
  localparam int GAP  = 255;
  localparam logic [47:0] SOF = 48'hEAFF99DEADFF;
  localparam logic [47:0] EOF = 48'hEAFF99DEADAA;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mipi_data;
  logic        mipi_valid;
  logic        fifo_full;
  logic [7:0]  fifo_data;
  logic        fifo_we;
  logic [7:0]  channel;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;
  logic [2:0]  dut_state;

  int total = 0;
  int bad   = 0;
  bit rand_full = 1'b0;

  logic [7:0] exp_bytes[$];
  logic [7:0] exp_done[$];
  logic [2:0] exp_err[$];

  mipi_frame_decoder #(.MAX_PAYLOAD(MAXP), .GAP_TIMEOUT(GAP)) dut (
    .rx_pixel_clk(clk),
    .rst(rst),
    .mipi_data(mipi_data),
    .mipi_valid(mipi_valid),
    .fifo_full(fifo_full),
    .fifo_data(fifo_data),
    .fifo_we(fifo_we),
    .channel(channel),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .err_code(err_code),
    .state(dut_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Random back-pressure while enabled.
  always @(posedge clk) begin
    #1;
    if (rand_full) fifo_full = ($urandom_range(0, 3) == 0);
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_we) begin
        chk("we_while_full", fifo_full, 1'b0);
        if (exp_bytes.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_write: got data %0h want no write", fifo_data);
        end else chk("fifo_data", fifo_data, exp_bytes.pop_front());
      end
      if (frame_done) begin
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: got channel %0h want no frame_done", channel);
        end else chk("done_channel", channel, exp_done.pop_front());
      end
      if (frame_err) begin
        if (exp_err.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_err: got err_code %0d want no frame_err", err_code);
        end else chk("err_code", err_code, exp_err.pop_front());
      end
    end
  end

  task automatic word(input logic [47:0] fw, input logic [15:0] pad);
    mipi_data  = {pad, fw[7:0], fw[15:8], fw[23:16], fw[31:24], fw[39:32], fw[47:40]};
    mipi_valid = 1'b1;
    @(posedge clk); #1;
    mipi_valid = 1'b0;
    mipi_data  = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic gapr(input int maxgap);
    idle($urandom_range(0, maxgap));
  endtask

  function automatic logic [47:0] meta(input logic [7:0] typ, input int len, input logic [7:0] ch);
    return {typ, 24'(len), ch, 8'h00};
  endfunction

  // Frame-level outcome: first violated rule wins, 0 means committed.
  function automatic int expect_code(input logic [7:0] typ, input int len,
                                     input int bad_idx, input bit eof_ok);
    if (typ != 8'h02) return 1;
    if (len < 1 || len > MAXP) return 2;
    if (bad_idx >= 0 && bad_idx < len) return 3;
    if (!eof_ok) return 4;
    return 0;
  endfunction

  task automatic wait_drained(input int budget);
    int n = 0;
    while ((dut_state != 3'd0 || exp_bytes.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL drain_timeout: state %0d pending %0d want idle", dut_state, exp_bytes.size());
    end
    idle(2);
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [7:0] typ, input int len,
                            input int bad_idx, input int bad_kind, input bit eof_ok,
                            input int maxgap);
    logic [7:0] pl[$];
    int code, nsend;
    nsend = (len >= 1 && len <= MAXP) ? len : 2;
    for (int i = 0; i < nsend; i++) pl.push_back(8'($urandom));
    code = expect_code(typ, len, bad_idx, eof_ok);
    if (code == 0) begin
      foreach (pl[i]) exp_bytes.push_back(pl[i]);
      exp_done.push_back(ch);
    end else exp_err.push_back(3'(code));
    word(SOF, 16'h0); gapr(maxgap);
    word(meta(typ, len, ch), 16'h0); gapr(maxgap);
    for (int i = 0; i < nsend; i++) begin
      if (i == bad_idx && bad_kind == 0) word({40'h0, pl[i]}, 16'h0001);
      else if (i == bad_idx)             word({40'h1, pl[i]}, 16'h0);
      else                               word({40'h0, pl[i]}, 16'h0);
      gapr(maxgap);
    end
    if (eof_ok) word(EOF, 16'h0);
    else        word({8'h55, 8'($urandom), 32'($urandom)}, 16'h0);
    wait_drained(400);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1; mipi_valid = 1'b0; mipi_data = '0; fifo_full = 1'b0;
    idle(3);
    chk("rst_fifo_we", fifo_we, 1'b0);
    chk("rst_fifo_data", fifo_data, 8'h00);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_err_code", err_code, 3'd0);
    chk("rst_channel", channel, 8'h00);
    chk("rst_state", dut_state, 3'd0);
    rst = 1'b0;
    idle(2);

    // Encoder-format single-byte frame, back-to-back words.
    exp_bytes.push_back(8'h41); exp_done.push_back(8'h01);
    word(SOF, 16'h0);
    word(meta(8'h02, 1, 8'h01), 16'h0);
    word(48'h41, 16'h0);
    word(EOF, 16'h0);
    @(negedge clk);
    chk("lat_fifo_we", fifo_we, 1'b1);
    chk("lat_fifo_data", fifo_data, 8'h41);
    chk("lat_done", frame_done, 1'b1);
    chk("lat_channel", channel, 8'h01);
    @(posedge clk); #1;
    chk("lat_state_idle", dut_state, 3'd0);
    chk("lat_we_off", fifo_we, 1'b0);
    idle(2);

    // len=3 with edge byte values, 2-cycle gaps, back-pressure during drain.
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h7F); exp_bytes.push_back(8'hFF);
    exp_done.push_back(8'h22);
    word(SOF, 16'h0); idle(2);
    word(meta(8'h02, 3, 8'h22), 16'h0); idle(2);
    word(48'h00, 16'h0); idle(2);
    word(48'h7F, 16'h0); idle(2);
    word(48'hFF, 16'h0); idle(2);
    word(EOF, 16'h0);
    fifo_full = 1'b1;
    idle(3);
    fifo_full = 1'b0;
    wait_drained(100);

    // Bad type, then a good frame; err_code must stay latched.
    send_frame(8'h05, 8'h03, 2, -1, 0, 1'b1, 1);
    send_frame(8'h06, 8'h02, 2, -1, 0, 1'b1, 1);
    chk("err_code_held", err_code, 3'd1);

    // Length bounds, wrong trailer, pad bits, header bits.
    send_frame(8'h07, 8'h02, 0, -1, 0, 1'b1, 1);
    send_frame(8'h07, 8'h02, MAXP + 1, -1, 0, 1'b1, 1);
    send_frame(8'h08, 8'h02, MAXP, -1, 0, 1'b1, 0);
    send_frame(8'h09, 8'h02, 2, -1, 0, 1'b0, 1);
    send_frame(8'h0A, 8'h02, 3, 1, 0, 1'b1, 1);
    send_frame(8'h0B, 8'h02, 3, 2, 1, 1'b1, 1);

    // Gap just under the limit is tolerated.
    exp_bytes.push_back(8'hA1); exp_bytes.push_back(8'hA2); exp_done.push_back(8'h31);
    word(SOF, 16'h0);
    word(meta(8'h02, 2, 8'h31), 16'h0); idle(GAP - 1);
    word(48'hA1, 16'h0); idle(GAP - 1);
    word(48'hA2, 16'h0); idle(GAP - 1);
    word(EOF, 16'h0);
    wait_drained(100);

    // Gap reaching the limit aborts the frame.
    exp_err.push_back(3'd5);
    word(SOF, 16'h0);
    word(meta(8'h02, 2, 8'h32), 16'h0);
    idle(GAP);
    chk("gap_state_idle", dut_state, 3'd0);
    idle(2);

    // SOF mid-payload resyncs onto the new frame.
    exp_err.push_back(3'd7);
    exp_bytes.push_back(8'h10); exp_bytes.push_back(8'h20); exp_done.push_back(8'h44);
    word(SOF, 16'h0);
    word(meta(8'h02, 4, 8'h33), 16'h0);
    word(48'hC1, 16'h0);
    word(48'hC2, 16'h0);
    word(SOF, 16'h0);
    word(meta(8'h02, 2, 8'h44), 16'h0);
    word(48'h10, 16'h0);
    word(48'h20, 16'h0);
    word(EOF, 16'h0);
    wait_drained(100);

    // SOF during drain is an overrun; the drain finishes regardless.
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'(8'h60 + i));
    exp_done.push_back(8'h66);
    word(SOF, 16'h0);
    word(meta(8'h02, 4, 8'h66), 16'h0);
    for (int i = 0; i < 4; i++) word({40'h0, 8'(8'h60 + i)}, 16'h0);
    word(EOF, 16'h0);
    fifo_full = 1'b1;
    exp_err.push_back(3'd6);
    word(SOF, 16'h0);
    chk("overrun_still_drain", dut_state, 3'd4);
    idle(2);
    fifo_full = 1'b0;
    wait_drained(100);

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'(8'h70 + i));
    exp_done.push_back(8'h77);
    word(SOF, 16'h0);
    word(meta(8'h02, 4, 8'h77), 16'h0);
    for (int i = 0; i < 4; i++) word({40'h0, 8'(8'h70 + i)}, 16'h0);
    word(EOF, 16'h0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_we", fifo_we, 1'b0);
    chk("rst_mid_state", dut_state, 3'd0);
    exp_bytes.delete();
    idle(2);
    rst = 1'b0;
    w = 0;
    repeat (8) begin @(negedge clk); w += int'(fifo_we); end
    chk("no_write_after_rst", w, 0);
    chk("rst_mid_err_code", err_code, 3'd0);
    idle(1);

    // Randomized traffic with idle words and back-pressure.
    rand_full = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int kind, len, bidx;
      logic [7:0] typ;
      kind = $urandom_range(0, 6);
      len  = $urandom_range(1, MAXP);
      typ  = 8'h02;
      bidx = -1;
      if (kind == 3) typ = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h00;
      if (kind == 4) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXP + 1, 255);
      if (kind == 5) bidx = $urandom_range(0, len - 1);
      repeat ($urandom_range(0, 3)) word(($urandom_range(0, 1) == 0) ? 48'h0 : {16'h1234, 32'($urandom)}, 16'h0);
      send_frame(8'($urandom), typ, len, bidx, $urandom_range(0, 1), kind != 6, 3);
    end
    rand_full = 1'b0;
    idle(2);
    fifo_full = 1'b0;
    idle(4);

    chk("left_bytes", exp_bytes.size(), 0);
    chk("left_done", exp_done.size(), 0);
    chk("left_err", exp_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mipi_frame_decoder.md
Name: mipi_frame_decoder

Overview:
- Receive-side counterpart of the MIPI frame encoder. Consumes 64-bit words from the MIPI RX pixel path and parses SOF / METADATA / PAYLOAD / EOF framing.
- Buffers payload bytes and commits them to the downstream byte FIFO (UART TX side) only after a valid EOF. Malformed frames are dropped and flagged.
- Sits between the MIPI CSI RX data output and the UART TX FIFO write port.

Parameters:
- MAX_PAYLOAD, 16: max payload words (bytes) per frame; also the staging buffer depth.
- GAP_TIMEOUT, 255: max rx_pixel_clk cycles without mipi_valid while inside a frame.

Ports:
- rx_pixel_clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-high.
- mipi_data  in  64  received word.
- mipi_valid  in  1  mipi_data valid this cycle.
- fifo_full  in  1  downstream FIFO full.
- fifo_data  out  8  byte to FIFO.
- fifo_we  out  1  FIFO write strobe.
- channel  out  8  channel byte of the last committed frame.
- frame_done  out  1  1-cycle pulse when a frame is committed.
- frame_err  out  1  1-cycle pulse when a frame is dropped.
- err_code  out  3  cause of the last frame_err; held until the next error.
- state  out  3  FSM state (debug).

Behaviour:
- Reset: all outputs 0, state=IDLE, buffer count 0, gap counter 0.
- Word unpack, fw[47:0] = {mipi_data[7:0], mipi_data[15:8], mipi_data[23:16], mipi_data[31:24], mipi_data[39:32], mipi_data[47:40]}.
- Pad bits: mipi_data[63:48] must be 0 inside a frame; nonzero → error 3.
- Constants: SOF fw=48'hEAFF99DEADFF. EOF fw=48'hEAFF99DEADAA.
- Only cycles with mipi_valid=1 are words. Words must arrive back-to-back in field order; each valid word advances the parse.
- States: IDLE=0, META=1, PAYLOAD=2, WAIT_EOF=3, DRAIN=4.
- IDLE:
  - Valid SOF → META.
  - All other words, including zero idle words, are ignored.
- META:
  - Require fw[47:40]=8'h02, else error 1.
  - len=fw[39:16]; require 1≤len≤MAX_PAYLOAD, else error 2.
  - Latch fw[15:8] as pending channel; ignore fw[7:0].
  - Load remaining count = len → PAYLOAD.
- PAYLOAD:
  - Each word: require fw[47:8]=0, else error 3.
  - Store fw[7:0] at buffer[idx], idx++.
  - When remaining reaches 0 → WAIT_EOF.
  - A payload byte of 0x00 (all-zero word) is legal.
- WAIT_EOF:
  - EOF → DRAIN. Pulse frame_done and update channel on the cycle DRAIN is entered.
  - Any other word → error 4.
- SOF seen in META/PAYLOAD/WAIT_EOF (checked before the field checks): error 7, discard buffer, go to META (resync, new frame starts).
- Gap timeout: in META/PAYLOAD/WAIT_EOF, the gap counter increments on each cycle with mipi_valid=0 and clears on valid. Reaching GAP_TIMEOUT → error 5, IDLE.
- Any error: frame_err pulses 1 cycle, err_code latched, buffer discarded, state=IDLE (except error 7 as above).
- DRAIN:
  - Each cycle with fifo_full=0: fifo_we=1, fifo_data=buffer[rd], rd++.
  - fifo_full=1: fifo_we=0, hold.
  - After the last byte → IDLE next cycle.
  - fifo_we never asserts while fifo_full=1.
- Overrun: a valid SOF during DRAIN → error 6 (frame_err pulse), that frame is dropped, and the drain continues unaffected. Non-SOF words in DRAIN are ignored.
- Latency: EOF accepted at cycle N → frame_done and first fifo_we at N+1 (if not full). Bytes are written in arrival order.
- Reset mid-frame or mid-drain: immediate return to reset values; no partial writes afterwards.

Test Plan:
- Encoder-format frame: SOF, meta fw=02_000001_01_00, payload fw=0x41, EOF on 4 consecutive valid cycles → cycle 5: fifo_we=1, fifo_data=0x41, frame_done=1, channel=0x01, state returns to 0.
- len=3, payloads 0x00/0x7F/0xFF with 2-cycle valid gaps; fifo_full high 3 cycles during drain → exactly 3 writes 00,7F,FF in order; no fifo_we while full.
- Meta type 0x03 → frame_err, err_code=1, no fifo_we; a following good frame is committed normally.
- len=0 and len=MAX_PAYLOAD+1 → err_code=2. SOF, meta, payload, then a non-EOF word → err_code=4. Pad bits mipi_data[63:48]=1 in a payload word → err_code=3.
- SOF, meta, then mipi_valid low GAP_TIMEOUT cycles → err_code=5, state=0. New SOF mid-PAYLOAD → err_code=7 and the new frame decodes correctly.
- SOF arriving during DRAIN → err_code=6 and the drain completes. Assert rst mid-DRAIN → fifo_we=0 immediately, state=0.
